// File: rtl/shift_reg_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : shift_reg_chain                                               |
// | Purpose  : Drives a daisy-chain of NUM_REGS 74hc595 shift registers.     |
// |            It serialises an 8*NUM_REGS-bit word onto o_SER_OUT. Each bit |
// |            gets a programmable SRCLK period. A single o_RCLK pulse then  |
// |            latches all devices together.                                 |
// | Ports    : i_clk       system clock (rising edge)                        |
// |            i_rst_n     synchronous reset, active-low                     |
// |            i_Data      parallel word, sampled on the accepting edge      |
// |            i_Enable    start request, level-sampled                      |
// |            o_Ready     idle / request will be accepted                   |
// |            o_Done      one-cycle pulse at the end of a transfer          |
// |            o_SRCLK     shift clock to the chain                          |
// |            o_RCLK      storage clock to the chain                        |
// |            o_SER_OUT   serial data to SER of the first device            |
// | Option   : SHIFT_REG_CHAIN_READBACK_EN adds these ports:                 |
// |              i_SER_IN (QH' of the last device)                           |
// |              o_ReadData (previous chain contents)                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module shift_reg_chain #(
    parameter int NUM_REGS  = 1,
    parameter int DURATION  = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
`ifdef SHIFT_REG_CHAIN_READBACK_EN
    input  logic                  i_SER_IN,
    output logic [8*NUM_REGS-1:0] o_ReadData,
`endif
    input  logic [8*NUM_REGS-1:0] i_Data,
    input  logic                  i_Enable,
    output logic                  o_Ready,
    output logic                  o_Done,
    output logic                  o_SRCLK,
    output logic                  o_RCLK,
    output logic                  o_SER_OUT
);

    localparam int c_WIDTH    = 8 * NUM_REGS;
    localparam int c_PH_WIDTH = (DURATION > 1) ? $clog2(DURATION) : 1;
    localparam int c_BIT_WIDTH = $clog2(c_WIDTH);

    localparam logic [c_PH_WIDTH-1:0]  c_PH_LAST  = c_PH_WIDTH'(DURATION - 1);
    localparam logic [c_BIT_WIDTH-1:0] c_BIT_LAST = c_BIT_WIDTH'(c_WIDTH - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SETUP   = 3'd1;
    localparam logic [2:0] c_ST_SCLK_HI = 3'd2;
    localparam logic [2:0] c_ST_GAP     = 3'd3;
    localparam logic [2:0] c_ST_LATCH   = 3'd4;
    localparam logic [2:0] c_ST_DONE    = 3'd5;

    logic [2:0]               r_state,  w_state_nxt;
    logic [c_PH_WIDTH-1:0]    r_phase,  w_phase_nxt;
    logic [c_BIT_WIDTH-1:0]   r_bit,    w_bit_nxt;
    logic [c_WIDTH-1:0]       r_shift,  w_shift_nxt;
    logic                     r_ready,  w_ready_nxt;
    logic                     r_done,   w_done_nxt;
    logic                     r_srclk,  w_srclk_nxt;
    logic                     r_rclk,   w_rclk_nxt;
    logic                     r_ser,    w_ser_nxt;
    logic                     w_phase_end;
    logic [c_WIDTH-1:0]       w_shifted;
`ifdef SHIFT_REG_CHAIN_READBACK_EN
    logic [c_WIDTH-1:0]       r_rx,        w_rx_nxt;
    logic [c_WIDTH-1:0]       r_read_data, w_read_data_nxt;
`endif

    // The bit about to be transmitted always sits at the end of the word
    // that leaves first, so shifting the opposite way exposes the next one.
    function automatic logic first_bit(input logic [c_WIDTH-1:0] x);
        return MSB_FIRST ? x[c_WIDTH-1] : x[0];
    endfunction

    assign w_phase_end = (r_phase == c_PH_LAST);
    assign w_shifted   = MSB_FIRST ? {r_shift[c_WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shift[c_WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_ready_nxt = r_ready;
        w_done_nxt  = 1'b0;
        w_srclk_nxt = r_srclk;
        w_rclk_nxt  = r_rclk;
        w_ser_nxt   = r_ser;
`ifdef SHIFT_REG_CHAIN_READBACK_EN
        w_rx_nxt        = r_rx;
        w_read_data_nxt = r_read_data;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (i_Enable) begin
                    w_shift_nxt = i_Data;
                    w_ser_nxt   = first_bit(i_Data);
                    w_bit_nxt   = '0;
                    w_phase_nxt = '0;
                    w_ready_nxt = 1'b0;
                    w_state_nxt = c_ST_SETUP;
                end
            end
            c_ST_SETUP: begin
                if (w_phase_end) begin
                    w_phase_nxt = '0;
                    w_srclk_nxt = 1'b1;
                    w_state_nxt = c_ST_SCLK_HI;
`ifdef SHIFT_REG_CHAIN_READBACK_EN
                    // SRCLK rises after this edge. QH' of the last device
                    // still shows the bit that is about to be pushed out.
                    w_rx_nxt = MSB_FIRST ? {r_rx[c_WIDTH-2:0], i_SER_IN}
                                         : {i_SER_IN, r_rx[c_WIDTH-1:1]};
`endif
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            c_ST_SCLK_HI: begin
                if (w_phase_end) begin
                    w_phase_nxt = '0;
                    w_srclk_nxt = 1'b0;
                    w_shift_nxt = w_shifted;
                    if (r_bit == c_BIT_LAST) begin
                        w_ser_nxt   = 1'b0;
                        w_state_nxt = c_ST_GAP;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_ser_nxt   = first_bit(w_shifted);
                        w_state_nxt = c_ST_SETUP;
                    end
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            c_ST_GAP: begin
                if (w_phase_end) begin
                    w_phase_nxt = '0;
                    w_rclk_nxt  = 1'b1;
                    w_state_nxt = c_ST_LATCH;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            c_ST_LATCH: begin
                if (w_phase_end) begin
                    w_phase_nxt = '0;
                    w_rclk_nxt  = 1'b0;
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            c_ST_DONE: begin
                // Ready and Done appear together. The FSM sits in IDLE while
                // they are visible, so a held Enable restarts on the next edge.
                w_ready_nxt = 1'b1;
                w_done_nxt  = 1'b1;
                w_state_nxt = c_ST_IDLE;
`ifdef SHIFT_REG_CHAIN_READBACK_EN
                w_read_data_nxt = r_rx;
`endif
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_ready_nxt = 1'b1;
                w_srclk_nxt = 1'b0;
                w_rclk_nxt  = 1'b0;
                w_ser_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= c_ST_IDLE;
            r_phase <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_srclk <= 1'b0;
            r_rclk  <= 1'b0;
            r_ser   <= 1'b0;
`ifdef SHIFT_REG_CHAIN_READBACK_EN
            r_rx        <= '0;
            r_read_data <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
            r_srclk <= w_srclk_nxt;
            r_rclk  <= w_rclk_nxt;
            r_ser   <= w_ser_nxt;
`ifdef SHIFT_REG_CHAIN_READBACK_EN
            r_rx        <= w_rx_nxt;
            r_read_data <= w_read_data_nxt;
`endif
        end
    end

    assign o_Ready   = r_ready;
    assign o_Done    = r_done;
    assign o_SRCLK   = r_srclk;
    assign o_RCLK    = r_rclk;
    assign o_SER_OUT = r_ser;
`ifdef SHIFT_REG_CHAIN_READBACK_EN
    assign o_ReadData = r_read_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_shift_reg_chain                                            |
// | Purpose  : Self-checking bench for shift_reg_chain. It uses two          |
// |            instances:                                                    |
// |              A: 1 device, DURATION=2, MSB first                          |
// |              B: 2 devices, DURATION=1, LSB first                         |
// |            Each instance drives a behavioural 595 chain model.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_shift_reg_chain;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        rst_n;
    logic        a_en, a_ready, a_done, a_srclk, a_rclk, a_ser;
    logic [7:0]  a_data;
    logic        b_en, b_ready, b_done, b_srclk, b_rclk, b_ser;
    logic [15:0] b_data;

    // Behavioural 595 chains: shift on SRCLK rise, latch on RCLK rise.
    logic [7:0]  a_chain = '0, a_latch = '0, a_preload_val = '0;
    logic        a_preload = 1'b0;
    logic [15:0] b_chain = '0, b_latch = '0;

`ifdef SHIFT_REG_CHAIN_READBACK_EN
    logic [7:0]  a_rd;
    logic [15:0] b_rd;
    logic        a_ser_in, b_ser_in;
    assign a_ser_in = a_chain[7];
    assign b_ser_in = b_chain[15];
`endif

    shift_reg_chain #(.NUM_REGS(1), .DURATION(2), .MSB_FIRST(1'b1)) u_dut_a (
        .i_clk     (i_clk),
        .i_rst_n   (rst_n),
`ifdef SHIFT_REG_CHAIN_READBACK_EN
        .i_SER_IN  (a_ser_in),
        .o_ReadData(a_rd),
`endif
        .i_Data    (a_data),
        .i_Enable  (a_en),
        .o_Ready   (a_ready),
        .o_Done    (a_done),
        .o_SRCLK   (a_srclk),
        .o_RCLK    (a_rclk),
        .o_SER_OUT (a_ser)
    );

    shift_reg_chain #(.NUM_REGS(2), .DURATION(1), .MSB_FIRST(1'b0)) u_dut_b (
        .i_clk     (i_clk),
        .i_rst_n   (rst_n),
`ifdef SHIFT_REG_CHAIN_READBACK_EN
        .i_SER_IN  (b_ser_in),
        .o_ReadData(b_rd),
`endif
        .i_Data    (b_data),
        .i_Enable  (b_en),
        .o_Ready   (b_ready),
        .o_Done    (b_done),
        .o_SRCLK   (b_srclk),
        .o_RCLK    (b_rclk),
        .o_SER_OUT (b_ser)
    );

    // Pin monitors: record bits at SRCLK rises and pulse widths. Timing
    // violations are counted as seen from the board side.
    int   a_rc_rise = 0, a_done_cnt = 0, a_viol = 0, a_ser_chg = 0;
    int   a_hi = 0, a_rc_hi = 0, a_rc_len = 0;
    bit   a_bits[$];
    logic a_p_srclk = 1'b0, a_p_rclk = 1'b0, a_p_ser = 1'b0;

    always @(negedge i_clk) begin
        if (a_preload) a_chain = a_preload_val;
        if (a_ser !== a_p_ser) begin
            if (a_p_srclk && a_srclk) a_viol++;
            a_ser_chg = cyc;
        end
        if (a_srclk && !a_p_srclk) begin
            a_bits.push_back(a_ser);
            if (cyc - a_ser_chg < 2) a_viol++;
            a_chain = {a_chain[6:0], a_ser};
            a_hi = 0;
        end
        if (a_srclk) a_hi++;
        if (!a_srclk && a_p_srclk && a_hi != 2) a_viol++;
        if (a_rclk && !a_p_rclk) begin
            a_rc_rise++;
            a_latch = a_chain;
            a_rc_hi = 0;
        end
        if (a_rclk) a_rc_hi++;
        if (!a_rclk && a_p_rclk) a_rc_len = a_rc_hi;
        if (a_done) a_done_cnt++;
        a_p_srclk = a_srclk;
        a_p_rclk  = a_rclk;
        a_p_ser   = a_ser;
    end

    int   b_rc_rise = 0, b_done_cnt = 0, b_viol = 0, b_ser_chg = 0;
    int   b_hi = 0, b_rc_hi = 0, b_rc_len = 0;
    bit   b_bits[$];
    logic b_p_srclk = 1'b0, b_p_rclk = 1'b0, b_p_ser = 1'b0;

    always @(negedge i_clk) begin
        if (b_ser !== b_p_ser) begin
            if (b_p_srclk && b_srclk) b_viol++;
            b_ser_chg = cyc;
        end
        if (b_srclk && !b_p_srclk) begin
            b_bits.push_back(b_ser);
            if (cyc - b_ser_chg < 1) b_viol++;
            b_chain = {b_chain[14:0], b_ser};
            b_hi = 0;
        end
        if (b_srclk) b_hi++;
        if (!b_srclk && b_p_srclk && b_hi != 1) b_viol++;
        if (b_rclk && !b_p_rclk) begin
            b_rc_rise++;
            b_latch = b_chain;
            b_rc_hi = 0;
        end
        if (b_rclk) b_rc_hi++;
        if (!b_rclk && b_p_rclk) b_rc_len = b_rc_hi;
        if (b_done) b_done_cnt++;
        b_p_srclk = b_srclk;
        b_p_rclk  = b_rclk;
        b_p_ser   = b_ser;
    end

    task automatic step();
        @(negedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] x);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = x[15 - i];
        return r;
    endfunction

    // One transfer on A. If poke > 0, a second request carrying 8'h00 is
    // pulsed poke cycles after acceptance, while the block is still busy.
    task automatic send_a(input logic [7:0] d, input int poke);
        int b0, r0, d0, v0, start, n;
        logic [7:0] w, pre;
        b0 = a_bits.size(); r0 = a_rc_rise; d0 = a_done_cnt; v0 = a_viol;
        pre = a_chain;
        a_data = d; a_en = 1'b1;
        step();
        start = cyc; a_en = 1'b0;
        chk("a_ready_low", a_ready, 1'b0);
        chk("a_first_bit", a_ser, d[7]);
        n = 0;
        while (a_done_cnt == d0 && n < 400) begin
            a_en   = (poke > 0) && (cyc - start == poke - 1);
            a_data = a_en ? 8'h00 : 8'($urandom);
            step();
            n++;
        end
        a_en = 1'b0;
        chk("a_done_seen", a_done_cnt - d0, 1);
        chk("a_latency", cyc - start, 37);
        chk("a_ready_at_done", a_ready, 1'b1);
        w = '0;
        for (int i = 0; i < 8; i++)
            if (b0 + i < a_bits.size()) w[7 - i] = a_bits[b0 + i];
        chk("a_srclk_rises", a_bits.size() - b0, 8);
        chk("a_bit_stream", w, d);
        chk("a_rclk_rises", a_rc_rise - r0, 1);
        chk("a_rclk_width", a_rc_len, 2);
        chk("a_timing_viol", a_viol - v0, 0);
        chk("a_latched", a_latch, d);
`ifdef SHIFT_REG_CHAIN_READBACK_EN
        chk("a_readback", a_rd, pre);
`endif
        step();
        chk("a_done_pulse", a_done, 1'b0);
    endtask

    task automatic send_b(input logic [15:0] d);
        int b0, r0, d0, v0, start, n;
        logic [15:0] w, pre;
        b0 = b_bits.size(); r0 = b_rc_rise; d0 = b_done_cnt; v0 = b_viol;
        pre = b_chain;
        b_data = d; b_en = 1'b1;
        step();
        start = cyc; b_en = 1'b0;
        chk("b_ready_low", b_ready, 1'b0);
        chk("b_first_bit", b_ser, d[0]);
        n = 0;
        while (b_done_cnt == d0 && n < 400) begin
            b_data = 16'($urandom);
            step();
            n++;
        end
        chk("b_done_seen", b_done_cnt - d0, 1);
        chk("b_latency", cyc - start, 35);
        chk("b_ready_at_done", b_ready, 1'b1);
        w = '0;
        for (int i = 0; i < 16; i++)
            if (b0 + i < b_bits.size()) w[i] = b_bits[b0 + i];
        chk("b_srclk_rises", b_bits.size() - b0, 16);
        chk("b_bit_stream", w, d);
        chk("b_rclk_rises", b_rc_rise - r0, 1);
        chk("b_rclk_width", b_rc_len, 1);
        chk("b_timing_viol", b_viol - v0, 0);
        chk("b_latched", b_latch, rev16(d));
`ifdef SHIFT_REG_CHAIN_READBACK_EN
        chk("b_readback", b_rd, rev16(pre));
`endif
        step();
        chk("b_done_pulse", b_done, 1'b0);
    endtask

    initial begin
        int s1, s2, n, d0, r0, b0;
        logic [15:0] w;

        rst_n = 1'b0; a_en = 1'b0; b_en = 1'b0; a_data = '0; b_data = '0;
        step();
        step();
        chk("rst_a_ready", a_ready, 1'b1);
        chk("rst_a_done",  a_done,  1'b0);
        chk("rst_a_srclk", a_srclk, 1'b0);
        chk("rst_a_rclk",  a_rclk,  1'b0);
        chk("rst_a_ser",   a_ser,   1'b0);
        chk("rst_b_ready", b_ready, 1'b1);
        chk("rst_b_srclk", b_srclk, 1'b0);
        chk("rst_b_ser",   b_ser,   1'b0);
`ifdef SHIFT_REG_CHAIN_READBACK_EN
        chk("rst_a_rd", a_rd, 8'h00);
        chk("rst_b_rd", b_rd, 16'h0000);
`endif
        rst_n = 1'b1;
        step();

        send_a(8'hA5, 0);
        send_b(16'h0001);

        // Busy protection: the second request must vanish without trace.
        d0 = a_done_cnt; b0 = a_bits.size();
        send_a(8'hFF, 5);
        repeat (50) step();
        chk("busy_single_done", a_done_cnt - d0, 1);
        chk("busy_bit_count", a_bits.size() - b0, 8);

        // Reset in the middle of a transfer aborts without any latch pulse.
        r0 = a_rc_rise; d0 = a_done_cnt;
        a_data = 8'($urandom); a_en = 1'b1;
        step();
        s1 = cyc; a_en = 1'b0;
        while (cyc < s1 + 9) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_srclk", a_srclk, 1'b0);
        chk("abort_rclk",  a_rclk,  1'b0);
        chk("abort_ser",   a_ser,   1'b0);
        chk("abort_ready", a_ready, 1'b1);
        repeat (60) step();
        chk("abort_no_rclk", a_rc_rise - r0, 0);
        chk("abort_no_done", a_done_cnt - d0, 0);
        send_a(8'h3C, 0);

        // Enable held high: back-to-back transfers with one idle cycle.
        d0 = a_done_cnt; r0 = a_rc_rise; b0 = a_bits.size();
        a_data = 8'h81; a_en = 1'b1;
        step();
        s1 = cyc;
        n = 0;
        while (a_done_cnt == d0 && n < 400) begin step(); n++; end
        chk("cont_first_latency", cyc - s1, 37);
        chk("cont_ready_seen", a_ready, 1'b1);
        a_data = 8'h7E;
        step();
        s2 = cyc;
        chk("cont_accept", a_ready, 1'b0);
        chk("cont_gap", s2 - s1, 38);
        chk("cont_second_first_bit", a_ser, 1'b0);
        n = 0;
        while (a_done_cnt == d0 + 1 && n < 400) begin step(); n++; end
        a_en = 1'b0;
        chk("cont_second_latency", cyc - s2, 37);
        chk("cont_rclk_rises", a_rc_rise - r0, 2);
        chk("cont_done_count", a_done_cnt - d0, 2);
        w = '0;
        for (int i = 0; i < 16; i++)
            if (b0 + i < a_bits.size()) w[15 - i] = a_bits[b0 + i];
        chk("cont_bit_stream", w, 16'h817E);
        chk("cont_latched", a_latch, 8'h7E);
        step();

`ifdef SHIFT_REG_CHAIN_READBACK_EN
        a_preload_val = 8'hC3; a_preload = 1'b1;
        step();
        a_preload = 1'b0;
        chk("preload_applied", a_chain, 8'hC3);
        send_a(8'h5A, 0);
`endif

        for (int i = 0; i < 3; i++) begin
            send_a(8'($urandom), 0);
            send_b(16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
